// File: rtl/char_rom_arbiter.sv
// Shares one registered character ROM between N_REQ text-layer requesters with a 3-stage valid/id pipeline.
// Build option CHAR_ARB_RR_EN: round-robin arbitration; undefined selects fixed priority (lowest index wins).
module char_rom_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 8,
  parameter int CODE_W = 7
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*ADDR_W-1:0]   i_req_addr,
  output logic [N_REQ-1:0]          o_gnt,
  output logic [ADDR_W-1:0]         o_rom_char_xy,
  input  logic [CODE_W-1:0]         i_rom_char_code,
  output logic [N_REQ-1:0]          o_rsp_valid,
  output logic [CODE_W-1:0]         o_rsp_char_code
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic              w_found;
  logic [ID_W-1:0]   w_win;
  logic [ADDR_W-1:0] w_addr;
  logic [N_REQ-1:0]  w_gnt;
  logic [N_REQ-1:0]  w_s2_onehot;

  logic              r_s1_valid;
  logic [ID_W-1:0]   r_s1_id;
  logic              r_s2_valid;
  logic [ID_W-1:0]   r_s2_id;

`ifdef CHAR_ARB_RR_EN
  logic [ID_W-1:0]   r_last_id;

  // Search starts just after the previous winner; the wrap is done by subtraction.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(r_last_id) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!w_found && i_req[idx]) begin
        w_found = 1'b1;
        w_win   = ID_W'(idx);
      end
    end
  end
`else
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_found = 1'b1;
        w_win   = ID_W'(i);
      end
    end
  end
`endif

  always_comb begin
    w_gnt  = '0;
    w_addr = i_req_addr[w_win*ADDR_W +: ADDR_W];
    if (w_found) w_gnt[w_win] = 1'b1;
  end

  always_comb begin
    w_s2_onehot = '0;
    if (r_s2_valid) w_s2_onehot[r_s2_id] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_gnt           <= '0;
      o_rom_char_xy   <= '0;
      r_s1_valid      <= 1'b0;
      r_s1_id         <= '0;
      r_s2_valid      <= 1'b0;
      r_s2_id         <= '0;
      o_rsp_valid     <= '0;
      o_rsp_char_code <= '0;
`ifdef CHAR_ARB_RR_EN
      r_last_id       <= ID_W'(N_REQ - 1);
`endif
    end else begin
      o_gnt      <= w_gnt;
      r_s1_valid <= w_found;
      r_s1_id    <= w_win;
      if (w_found) begin
        o_rom_char_xy <= w_addr;
`ifdef CHAR_ARB_RR_EN
        r_last_id     <= w_win;
`endif
      end
      r_s2_valid  <= r_s1_valid;
      r_s2_id     <= r_s1_id;
      o_rsp_valid <= w_s2_onehot;
      // The code only moves on real lookups, so idle gaps keep the last returned value.
      if (r_s2_valid) o_rsp_char_code <= i_rom_char_code;
    end
  end

endmodule

// File: tb/tb_char_rom_arbiter.sv
// Directed bench for char_rom_arbiter with a title-ROM model and a response scoreboard.
// Honours CHAR_ARB_RR_EN to select the expected arbitration policy.
module tb_char_rom_arbiter;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int CW = 7;
  localparam int EW = 16 + N + CW;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    gnt;
  logic [AW-1:0]   rom_xy;
  logic [CW-1:0]   rom_code;
  logic [N-1:0]    rsp_valid;
  logic [CW-1:0]   rsp_code;

  logic [EW-1:0] exp_q[$];
  logic [AW-1:0] exp_xy;
  int            cyc;
  int            n_cmp;
  int            n_fail;
`ifdef CHAR_ARB_RR_EN
  int            m_last;
`endif

  char_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .CODE_W(CW)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req           (req),
    .i_req_addr      (req_addr),
    .o_gnt           (gnt),
    .o_rom_char_xy   (rom_xy),
    .i_rom_char_code (rom_code),
    .o_rsp_valid     (rsp_valid),
    .o_rsp_char_code (rsp_code)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Title ROM: "PLATFORMICO!" at 0x00..0x0B, other addresses return their own low bits.
  function automatic logic [CW-1:0] rom_f(input logic [AW-1:0] a);
    logic [95:0] s;
    int ai;
    s  = "PLATFORMICO!";
    ai = int'(a);
    if (ai < 12) return s[(11-ai)*8 +: CW];
    return a[CW-1:0];
  endfunction

  initial rom_code = '0;
  always @(posedge clk) rom_code <= rom_f(rom_xy);

  function automatic int model_win(input logic [N-1:0] r);
`ifdef CHAR_ARB_RR_EN
    for (int k = 1; k <= N; k++) begin
      if (r[(m_last + k) % N]) return (m_last + k) % N;
    end
`else
    for (int i = 0; i < N; i++) begin
      if (r[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // One clock: predict the grant from the inputs now driven, then check all outputs.
  task automatic step();
    int            w;
    logic [N-1:0]  oh;
    logic [EW-1:0] e;
    w = rst ? -1 : model_win(req);
    @(posedge clk);
    cyc++;
    #1;
    oh = '0;
    if (w >= 0) oh[w] = 1'b1;
    chk("gnt", 32'(gnt), 32'(oh));
    if (w >= 0) begin
      exp_xy = req_addr[w*AW +: AW];
      exp_q.push_back({cyc[15:0] + 16'd2, oh, rom_f(exp_xy)});
`ifdef CHAR_ARB_RR_EN
      m_last = w;
`endif
    end
    chk("rom_char_xy", 32'(rom_xy), 32'(exp_xy));
    if (exp_q.size() > 0 && exp_q[0][EW-1 -: 16] == cyc[15:0]) begin
      e = exp_q.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 32'(e[CW+N-1 -: N]));
      chk("rsp_char_code", 32'(rsp_code), 32'(e[CW-1:0]));
    end else begin
      chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_code"}, 32'(rsp_code), 32'd0);
    chk({tag, "_rom_xy"}, 32'(rom_xy), 32'd0);
  endtask

  initial begin
    logic [AW-1:0] stream [13];
    n_cmp = 0; n_fail = 0; cyc = 0;
    exp_xy = '0;
`ifdef CHAR_ARB_RR_EN
    m_last = N - 1;
`endif
    req = '0; req_addr = '0;
    for (int i = 0; i < 12; i++) stream[i] = AW'(i);
    stream[12] = 8'h20;

    // Reset and idle
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_rsp_code", 32'(rsp_code), 32'd0);
    end

    // Single lookup: requester 0, address 0x00 -> 'P'
    req = 2'b01; req_addr[0 +: AW] = 8'h00;
    step();
    req = '0;
    repeat (4) step();

    // Back-to-back stream on requester 1, new address in the cycle after each grant
    req = 2'b10; req_addr[AW +: AW] = stream[0];
    for (int i = 0; i < 13; i++) begin
      step();
      if (i < 12) req_addr[AW +: AW] = stream[i+1];
      else        req = '0;
    end
    repeat (4) step();

    // Contention: both held, '!' from requester 0, 'A' from requester 1
    req_addr[0 +: AW]  = 8'h0B;
    req_addr[AW +: AW] = 8'h02;
    req = 2'b11;
    repeat (8) step();
    req = '0;
    repeat (4) step();

    // Reset in the cycle after a grant: in-flight lookups are dropped
    req = 2'b11;
    step();
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    exp_xy = '0;
`ifdef CHAR_ARB_RR_EN
    m_last = N - 1;
`endif
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("post_reset_gnt0", 32'(gnt), 32'd1);
    req = '0;
    repeat (4) step();

    // Random single-cycle requests with random addresses
    for (int i = 0; i < 40; i++) begin
      req = N'($urandom_range(0, (1 << N) - 1));
      for (int r = 0; r < N; r++) req_addr[r*AW +: AW] = AW'($urandom_range(0, 8'h2F));
      step();
    end
    req = '0;
    repeat (4) step();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
